wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back end of the MEM/WB pipeline interface: consumes the MEM/WB register outputs,
//  selects the write-back value, commits it to the integer register file, and serves
//  ID-stage reads on two ports.
//  Also exports the selected write-back value for EX forwarding and a retired-write counter.
// PARAMETERS
//  XLEN      32   data width of registers and write-back data
//  REG_AW    5    register address width (2**REG_AW registers; register 0 is hard zero)
//  CNT_W     32   width of retired-write counter
// PORTS
//  clk_i        in   1       clock, all state updates on posedge
//  rst_n_i      in   1       asynchronous, active-low reset
//  RegWrite_i   in   1       MEM/WB: write enable for rd
//  MemReg_i     in   1       MEM/WB: 1 = write memory data (data1_i), 0 = ALU result (data2_i)
//  rd_addr_i    in   REG_AW  MEM/WB: destination register
//  data1_i      in   XLEN    MEM/WB: memory read data
//  data2_i      in   XLEN    MEM/WB: ALU result
//  rs1_addr_i   in   REG_AW  ID read port 1 address
//  rs2_addr_i   in   REG_AW  ID read port 2 address
//  rs1_data_o   out  XLEN    read port 1 data (combinational)
//  rs2_data_o   out  XLEN    read port 2 data (combinational)
//  wb_data_o    out  XLEN    selected write-back value (combinational, for forwarding)
//  wb_valid_o   out  1       RegWrite_i && rd_addr_i != 0 (forwarding qualifier)
//  retire_cnt_o out  CNT_W   count of committed register writes
// BEHAVIOUR
//  - wb_data_o = MemReg_i ? data1_i : data2_i; pure mux, no latency.
//  - Commit: on posedge with rst_n_i=1, RegWrite_i=1 and rd_addr_i!=0 -> regs[rd_addr_i] <= wb_data_o.
//  - Writes to register 0 are discarded; reads of register 0 always return 0 (bypass included).
//  - Reads: rs*_data_o = regs[rs*_addr_i]; combinational, zero cycles.
//  - The value written at edge N is visible on the read ports after edge N.
//  - retire_cnt_o increments by 1 on every committed write; it is not incremented for writes to reg 0.
//  - retire_cnt_o wraps from 2**CNT_W-1 to 0 without a flag.
//  - Reset: when rst_n_i falls, immediately (asynchronously) all regs=0 and retire_cnt_o=0.
//    No commit occurs while rst_n_i=0; an in-flight write at the reset edge is lost.
//    The combinational outputs during reset follow the inputs; read data = 0.
//  - Both read ports may address the same register or rd_addr_i simultaneously; no conflict.
//  - Unknown (X) RegWrite_i must not corrupt state: commit is gated on RegWrite_i===1 in simulation.
// CONFIGURATION
//  WB_BYPASS_EN defined: same-cycle write-through. If RegWrite_i=1, rd_addr_i!=0 and
//    rs*_addr_i==rd_addr_i, then rs*_data_o = wb_data_o in the same cycle.
//    This removes the need for a split-phase register file.
//  WB_BYPASS_EN undefined: rs*_data_o returns the pre-commit (old) value in that cycle.
//    The hazard unit must then stall one cycle.
// STRUCTURE
//  Package wb_pkg: XLEN, REG_AW, ZERO_REG='0, typedef reg_addr_t, typedef xword_t.
//  Sub-module regfile_2r1w: storage array + async reset + zero-register rule.
//  The top level holds the write-back mux, bypass (under WB_BYPASS_EN), and retire counter.
// TESTING
//  1 Reset: hold rst_n_i=0 and read all 32 addresses -> all 0; retire_cnt_o=0.
//  2 ALU write: RegWrite=1, MemReg=0, rd=5, data2=0xDEADBEEF; next cycle rs1=5 -> 0xDEADBEEF, cnt=1.
//  3 Mem write: RegWrite=1, MemReg=1, rd=7, data1=0x12345678, data2=0xFFFFFFFF -> reg7=0x12345678.
//  4 Zero reg: RegWrite=1, rd=0, data2=0xAAAA5555 -> rs1=0 reads 0, wb_valid_o=0, cnt unchanged.
//  5 Same-cycle read: write rd=3 to 0x1 while rs2=3 and reg3 holds 0x9.
//    Bypass defined -> 0x1; bypass undefined -> 0x9 then 0x1.
//  6 Reset mid-op: write reg9=0x55, then assert rst_n_i between edges -> reg9 reads 0 immediately.
//    A write presented at the following edge is not committed; cnt=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back stage and its register file.
// Provides default widths, the hard-zero register address and word/address types.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;
    localparam int NREGS  = 1 << REG_AW;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xword_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read / one-write integer register file with async active-low clear.
// Ports: clk_i, rst_n_i, we_i/waddr_i/wdata_i (write), raddr*_i -> rdata*_o (comb).
module regfile_2r1w
    import wb_pkg::*;
#(
    parameter int XLEN   = wb_pkg::XLEN,
    parameter int REG_AW = wb_pkg::REG_AW
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata1_o,
    output logic [XLEN-1:0]   rdata2_o
);

    localparam int N = 1 << REG_AW;

    logic [XLEN-1:0] regs_q [N];
    logic [XLEN-1:0] regs_d [N];

    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != '0)) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Entry 0 is never written, but the explicit mux keeps x0 at zero
    // regardless of what the flop holds.
    always_comb begin
        rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
        rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects MEM/WB result, commits it to the register file,
// serves two ID read ports, exports wb data/valid for forwarding and a
// retired-write counter. Optional WB_BYPASS_EN: same-cycle write-through.
module wb_regfile
    import wb_pkg::*;
#(
    parameter int XLEN   = wb_pkg::XLEN,
    parameter int REG_AW = wb_pkg::REG_AW,
    parameter int CNT_W  = wb_pkg::CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              RegWrite_i,
    input  logic              MemReg_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [XLEN-1:0]   data1_i,
    input  logic [XLEN-1:0]   data2_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              wb_valid_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);

    logic [XLEN-1:0]  wb_data;
    logic             we_known;
    logic             commit;
    logic [XLEN-1:0]  rf_rd1;
    logic [XLEN-1:0]  rf_rd2;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign wb_data = MemReg_i ? data1_i : data2_i;

    // Case equality so an unknown enable never commits in simulation;
    // synthesis treats it as a plain compare.
    assign we_known = (RegWrite_i === 1'b1);
    assign commit   = we_known && (rd_addr_i != '0);

    assign wb_data_o  = wb_data;
    assign wb_valid_o = RegWrite_i && (rd_addr_i != '0);

    regfile_2r1w #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_rf (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .we_i     (commit),
        .waddr_i  (rd_addr_i),
        .wdata_i  (wb_data),
        .raddr1_i (rs1_addr_i),
        .raddr2_i (rs2_addr_i),
        .rdata1_o (rf_rd1),
        .rdata2_o (rf_rd2)
    );

`ifdef WB_BYPASS_EN
    logic byp1;
    logic byp2;

    // Gated by reset so read data stays zero while the file is held clear.
    always_comb begin
        byp1       = rst_n_i && commit && (rs1_addr_i == rd_addr_i);
        byp2       = rst_n_i && commit && (rs2_addr_i == rd_addr_i);
        rs1_data_o = byp1 ? wb_data : rf_rd1;
        rs2_data_o = byp2 ? wb_data : rf_rd2;
    end
`else
    always_comb begin
        rs1_data_o = rf_rd1;
        rs2_data_o = rf_rd2;
    end
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (commit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed table-driven bench for wb_regfile plus reset/wrap sequences.
`timescale 1ns/100ps
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        rw;
    logic        mr;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic [31:0] cnt;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_wb_data;
    logic        w_wb_valid;
    logic [2:0]  w_cnt;

    int checks   = 0;
    int failures = 0;

    wb_regfile dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .RegWrite_i   (rw),
        .MemReg_i     (mr),
        .rd_addr_i    (rd),
        .data1_i      (d1),
        .data2_i      (d2),
        .rs1_addr_i   (rs1),
        .rs2_addr_i   (rs2),
        .rs1_data_o   (rs1_data),
        .rs2_data_o   (rs2_data),
        .wb_data_o    (wb_data),
        .wb_valid_o   (wb_valid),
        .retire_cnt_o (cnt)
    );

    wb_regfile #(.CNT_W(3)) dut_w (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .RegWrite_i   (rw),
        .MemReg_i     (mr),
        .rd_addr_i    (rd),
        .data1_i      (d1),
        .data2_i      (d2),
        .rs1_addr_i   (rs1),
        .rs2_addr_i   (rs2),
        .rs1_data_o   (w_rs1_data),
        .rs2_data_o   (w_rs2_data),
        .wb_data_o    (w_wb_data),
        .wb_valid_o   (w_wb_valid),
        .retire_cnt_o (w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        mr;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ewb;
        logic        ev;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected read value for a port: pre-commit value, or the write-back
    // value when same-cycle write-through is built in.
    function automatic logic [31:0] exp_rd(input logic [31:0] old_v,
                                           input logic [4:0] a,
                                           input vec_t v);
`ifdef WB_BYPASS_EN
        if (v.rw && v.rd != 5'd0 && a == v.rd) return v.ewb;
`endif
        return old_v;
    endfunction

    initial begin
        //         rw    mr    rd    d1            d2            rs1   rs2   e1            e2            ewb           ev    ecnt
        vt[0] = '{1'b1, 1'b0, 5'd5, 32'h0,        32'hDEADBEEF, 5'd0, 5'd0, 32'h0,        32'h0,        32'hDEADBEEF, 1'b1, 32'd0};
        vt[1] = '{1'b1, 1'b1, 5'd7, 32'h12345678, 32'hFFFFFFFF, 5'd5, 5'd7, 32'hDEADBEEF, 32'h0,        32'h12345678, 1'b1, 32'd1};
        vt[2] = '{1'b1, 1'b0, 5'd0, 32'h0,        32'hAAAA5555, 5'd0, 5'd7, 32'h0,        32'h12345678, 32'hAAAA5555, 1'b0, 32'd2};
        vt[3] = '{1'b1, 1'b0, 5'd3, 32'h0,        32'h9,        5'd0, 5'd3, 32'h0,        32'h0,        32'h9,        1'b1, 32'd2};
        vt[4] = '{1'b1, 1'b0, 5'd3, 32'h0,        32'h1,        5'd3, 5'd3, 32'h9,        32'h9,        32'h1,        1'b1, 32'd3};
        vt[5] = '{1'b0, 1'b0, 5'd3, 32'h0,        32'h77,       5'd3, 5'd5, 32'h1,        32'hDEADBEEF, 32'h77,       1'b0, 32'd4};
        vt[6] = '{1'b0, 1'b1, 5'd3, 32'h88,       32'h99,       5'd3, 5'd0, 32'h1,        32'h0,        32'h88,       1'b0, 32'd4};

        rst_n = 1'b0;
        rw = 1'b0; mr = 1'b0; rd = '0; d1 = '0; d2 = '0;
        rs1 = '0; rs2 = '0;

        // Reset: every address reads zero, counter is zero.
        for (int a = 0; a < 32; a++) begin
            rs1 = 5'(a);
            rs2 = 5'(31 - a);
            #1;
            check("rst_rs1", 64'(rs1_data), 64'h0);
            check("rst_rs2", 64'(rs2_data), 64'h0);
        end
        check("rst_cnt", 64'(cnt), 64'h0);
        check("rst_cnt_w", 64'(w_cnt), 64'h0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rw  = vt[i].rw;
            mr  = vt[i].mr;
            rd  = vt[i].rd;
            d1  = vt[i].d1;
            d2  = vt[i].d2;
            rs1 = vt[i].rs1;
            rs2 = vt[i].rs2;
            #2;
            check($sformatf("v%0d_rs1", i), 64'(rs1_data),
                  64'(exp_rd(vt[i].e1, vt[i].rs1, vt[i])));
            check($sformatf("v%0d_rs2", i), 64'(rs2_data),
                  64'(exp_rd(vt[i].e2, vt[i].rs2, vt[i])));
            check($sformatf("v%0d_wb", i), 64'(wb_data), 64'(vt[i].ewb));
            check($sformatf("v%0d_valid", i), 64'(wb_valid), 64'(vt[i].ev));
            check($sformatf("v%0d_cnt", i), 64'(cnt), 64'(vt[i].ecnt));
            check($sformatf("v%0d_cnt_w", i), 64'(w_cnt),
                  64'(vt[i].ecnt % 8));
        end

        // Four more commits: 32-bit counter reaches 8, 3-bit one wraps to 0.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rw = 1'b1; mr = 1'b0;
            rd = 5'(10 + i);
            d2 = 32'h100 + 32'(i);
            rs1 = '0; rs2 = '0;
        end
        @(negedge clk);
        rw = 1'b0; rs1 = 5'd10; rs2 = 5'd13;
        #2;
        check("wrap_rs1", 64'(rs1_data), 64'h100);
        check("wrap_rs2", 64'(rs2_data), 64'h103);
        check("wrap_cnt", 64'(cnt), 64'd8);
        check("wrap_cnt_w", 64'(w_cnt), 64'd0);

        // Reset in the middle of operation.
        @(negedge clk);
        rw = 1'b1; mr = 1'b0; rd = 5'd9; d2 = 32'h55;
        @(negedge clk);
        rw = 1'b0; rs1 = 5'd9;
        #2;
        check("r9_pre", 64'(rs1_data), 64'h55);
        check("cnt_pre", 64'(cnt), 64'd9);
        #1;
        rst_n = 1'b0;
        rw = 1'b1; rd = 5'd9; d2 = 32'h66;
        #1;
        check("r9_async", 64'(rs1_data), 64'h0);
        check("cnt_async", 64'(cnt), 64'h0);
        check("cnt_w_async", 64'(w_cnt), 64'h0);
        check("rst_wb", 64'(wb_data), 64'h66);
        check("rst_valid", 64'(wb_valid), 64'h1);
        @(posedge clk);
        #1;
        check("r9_rst_edge", 64'(rs1_data), 64'h0);
        check("cnt_rst_edge", 64'(cnt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rw = 1'b0;
        #2;
        check("r9_rel", 64'(rs1_data), 64'h0);
        @(posedge clk);
        #1;
        check("r9_post", 64'(rs1_data), 64'h0);
        check("cnt_post", 64'(cnt), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
